// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader_if
//  Brief    : Stream input and instruction-memory write bus of the boot loader
//  Revision : 1.0
// ============================================================================

interface inst_mem_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;

    // master: the loader side; slave: host FIFO plus instruction memory
    modport master (
        input  s_data, s_valid,
        output s_ready, m_address, m_writedata, m_byteenable, m_chipselect, m_write
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, m_address, m_writedata, m_byteenable, m_chipselect, m_write
    );
endinterface

`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader
//  Brief    : Streams a header/data/checksum image into instruction memory
//             while holding the CPU in reset
//  Revision : 1.0
// ============================================================================

module inst_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           start,
    inst_mem_loader_if.master   bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_ADDR = 3'd1,
        HDR_CNT  = 3'd2,
        DATA     = 3'd3,
        CSUM     = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam int          CNT_W     = 16;
    localparam logic [16:0] MAX_COUNT = 17'(DEPTH);

    state_t             state;
    logic               ready;
    logic               mem_cs;
    logic               mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]   remaining;
    logic [DATA_W-1:0]  sum;

    logic               fire;
    logic [CNT_W-1:0]   cnt_word;

    assign fire     = bus.s_valid & ready;
    assign cnt_word = bus.s_data[CNT_W-1:0];

    assign bus.s_ready      = ready;
    assign bus.m_chipselect = mem_cs;
    assign bus.m_write      = mem_wr;
    assign bus.m_address    = mem_addr;
    assign bus.m_writedata  = mem_wdata;
    assign bus.m_byteenable = 4'hF;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ready     <= 1'b0;
            mem_cs    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            sum       <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // write strobes are single-cycle pulses unless a DATA beat refires them
            mem_cs <= 1'b0;
            mem_wr <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= HDR_ADDR;
                        ready     <= 1'b1;
                        busy      <= 1'b1;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        sum       <= '0;
                        remaining <= '0;
                        wr_ptr    <= '0;
                    end
                end

                HDR_ADDR: begin
                    if (fire) begin
                        wr_ptr <= bus.s_data[ADDR_W-1:0];
                        state  <= HDR_CNT;
                    end
                end

                HDR_CNT: begin
                    if (fire) begin
                        remaining <= cnt_word;
                        if ({1'b0, cnt_word} > MAX_COUNT) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            ready    <= 1'b0;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else if (cnt_word == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (fire) begin
                        mem_cs    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= bus.s_data;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        sum       <= sum + bus.s_data;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (fire) begin
                        ready    <= 1'b0;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        if (bus.s_data == sum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    ready    <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Brief    : Vector table plus hand sequences; writes tracked by a scoreboard
//  Revision : 1.0
// ============================================================================

module tb_inst_mem_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, error;

    inst_mem_loader_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    inst_mem_loader #(.ADDR_W(14), .DATA_W(32), .DEPTH(16384)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus.master),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t sb[$];

    always @(negedge clk) begin
        if (bus.m_chipselect || bus.m_write) begin
            wr_t e;
            chk("wr_strobe_pair", bus.m_write, bus.m_chipselect);
            chk("wr_byteenable", bus.m_byteenable, 32'hF);
            chk("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", bus.m_address, e.addr);
                chk("wr_data", bus.m_writedata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit gaps);
        int tmo = 0;
        bit acc;
        if (gaps) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        forever begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
            if (acc) break;
            tmo++;
            if (tmo > 20) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: s_ready stayed 0 for 20 cycles, data %0h", d);
                break;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       cnt;
        logic [3:0][31:0]  d;
        logic [31:0]       csum;
        bit                gaps;
        bit                auto_csum;
        bit                exp_done;
        bit                exp_err;
    } vec_t;

    function automatic logic [31:0] beat_data(input vec_t v, input int i);
        if (i < 4) return v.d[i];
        return 32'(i) * 32'h9E37_79B9;
    endfunction

    task automatic run_load(input vec_t v, input string tag);
        logic [13:0] a;
        logic [15:0] n;
        logic [31:0] s;
        logic [31:0] d;
        pulse_start();
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_hold_rise"}, cpu_hold, 1);
        chk({tag, "_ready_rise"}, bus.s_ready, 1);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_err_clr"}, error, 0);
        send_beat(v.addr, v.gaps);
        send_beat(v.cnt, v.gaps);
        n = v.cnt[15:0];
        a = v.addr[13:0];
        s = '0;
        if (n <= 16'd16384) begin
            for (int i = 0; i < int'(n); i++) begin
                d = beat_data(v, i);
                send_beat(d, v.gaps);
                sb.push_back('{addr: a, data: d, cyc: cyc});
                a = a + 14'd1;
                s = s + d;
            end
            send_beat(v.auto_csum ? s : v.csum, v.gaps);
        end
        chk({tag, "_done"}, done, 32'(v.exp_done));
        chk({tag, "_error"}, error, 32'(v.exp_err));
        chk({tag, "_hold_fall"}, cpu_hold, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_ready_fall"}, bus.s_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] s;
        logic [31:0] d;
        logic [13:0] a;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        vecs[0] = '{addr: 32'h0000_0010, cnt: 32'd4, d: {32'd4, 32'd3, 32'd2, 32'd1},
                    csum: 32'h0000_000A, gaps: 0, auto_csum: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{addr: 32'h0000_3FFE, cnt: 32'd4, d: {32'h44, 32'h33, 32'h22, 32'h11},
                    csum: 32'h0000_00AA, gaps: 0, auto_csum: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{addr: 32'h0000_0020, cnt: 32'd2, d: {32'd0, 32'd0, 32'd6, 32'd5},
                    csum: 32'h0000_000C, gaps: 0, auto_csum: 0, exp_done: 0, exp_err: 1};
        vecs[3] = '{addr: 32'h0000_0000, cnt: 32'h0000_4001, d: '0,
                    csum: 32'h0, gaps: 0, auto_csum: 0, exp_done: 0, exp_err: 1};
        vecs[4] = '{addr: 32'h0000_0040, cnt: 32'd0, d: '0,
                    csum: 32'h0, gaps: 0, auto_csum: 0, exp_done: 1, exp_err: 0};
        vecs[5] = '{addr: 32'h0000_0100, cnt: 32'd2, d: {32'd0, 32'd0, 32'h2, 32'hFFFF_FFFF},
                    csum: 32'h0000_0001, gaps: 1, auto_csum: 0, exp_done: 1, exp_err: 0};
        // upper bits of both header words must be ignored
        vecs[6] = '{addr: 32'hABCD_0010, cnt: 32'hFFFF_0001, d: {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF},
                    csum: 32'hDEAD_BEEF, gaps: 0, auto_csum: 0, exp_done: 1, exp_err: 0};
        vecs[7] = '{addr: 32'h0000_1234, cnt: 32'h0000_4000, d: {32'h7, 32'h6, 32'h5, 32'h4},
                    csum: 32'h0, gaps: 0, auto_csum: 1, exp_done: 1, exp_err: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_cs", bus.m_chipselect, 0);
        chk("rst_write", bus.m_write, 0);
        chk("rst_addr", bus.m_address, 0);
        chk("rst_wdata", bus.m_writedata, 0);
        chk("rst_be", bus.m_byteenable, 32'hF);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
        end

        // beats offered after DONE are not consumed
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h5555_5555;
        repeat (2) begin
            @(negedge clk);
            chk("done_no_ready", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;

        // start held high during header and data beats must not restart the load
        pulse_start();
        send_beat(32'h300, 0);
        start = 1'b1;
        send_beat(32'd3, 0);
        start = 1'b0;
        a = 14'h300;
        s = '0;
        for (int i = 0; i < 3; i++) begin
            d = 32'h1000 + 32'(i);
            start = (i == 1);
            send_beat(d, 0);
            start = 1'b0;
            sb.push_back('{addr: a, data: d, cyc: cyc});
            a = a + 14'd1;
            s = s + d;
        end
        send_beat(s, 0);
        chk("restart_done", done, 1);
        chk("restart_error", error, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_sb_drained", sb.size(), 0);

        // reset after two of four data beats
        pulse_start();
        send_beat(32'h200, 0);
        send_beat(32'd4, 0);
        a = 14'h200;
        for (int i = 0; i < 2; i++) begin
            d = 32'hA000 + 32'(i);
            send_beat(d, 0);
            sb.push_back('{addr: a, data: d, cyc: cyc});
            a = a + 14'd1;
        end
        reset_n = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hA002;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_ready", bus.s_ready, 0);
        chk("midrst_cs", bus.m_chipselect, 0);
        chk("midrst_write", bus.m_write, 0);
        chk("midrst_addr", bus.m_address, 0);
        chk("midrst_wdata", bus.m_writedata, 0);
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        repeat (4) begin
            @(negedge clk);
            chk("midrst_idle_ready", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
        #1;
        chk("midrst_sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

Stream-to-memory boot loader that sits directly upstream of the on-chip instruction memory (single-port, 16384 x 32, byte-enabled Avalon slave). It consumes 32-bit words from the host FIFO and writes them into instruction memory. It holds the Nios CPU in reset while loading, and it verifies a trailing checksum. It drives the memory's `chipselect`/`write`/`address`/`writedata`/`byteenable` inputs through the memory's write-side port mux.

## Interface
- `ADDR_W`, 14: memory word-address width.
- `DATA_W`, 32: stream and memory data width.
- `DEPTH`, 16384: maximum word count accepted; must equal 2^`ADDR_W`.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that arms a load; ignored while `busy`=1.
- `s_data`, in, `DATA_W`: stream word from the FIFO.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: loader accepts a word; a beat transfers when `s_valid`&`s_ready`.
- `m_address`, out, `ADDR_W`: memory word address.
- `m_writedata`, out, `DATA_W`: memory write data.
- `m_byteenable`, out, 4: constant 4'hF.
- `m_chipselect`, out, 1: memory access strobe.
- `m_write`, out, 1: write strobe, asserted together with `m_chipselect`.
- `cpu_hold`, out, 1: CPU reset request; high from load start until DONE or ERR.
- `busy`, out, 1: high in any state other than IDLE, DONE or ERR.
- `done`, out, 1: sticky; load completed with a matching checksum.
- `error`, out, 1: sticky; the word count is illegal or the checksum does not match.

## Operation
- States: IDLE, HDR_ADDR, HDR_CNT, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR to HDR_ADDR: on `start`. This clears `done`, `error`, the checksum accumulator and the word index, and sets `cpu_hold`.
- HDR_ADDR: the accepted beat is the start address, taken from `s_data[ADDR_W-1:0]`; upper bits are ignored. Next state is HDR_CNT.
- HDR_CNT: the accepted beat is the word count N, taken from `s_data[15:0]`.
  - N > `DEPTH`: go to ERR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: each accepted beat is written to address (start + index) mod 2^`ADDR_W`; the address wraps from 16383 to 0.
  - Checksum accumulator `sum` += beat, computed mod 2^32.
  - Index increments on each beat; after beat N the state goes to CSUM.
- CSUM: the accepted beat is compared with `sum`.
  - Equal: go to DONE, with `done`=1.
  - Not equal: go to ERR, with `error`=1.
  - `cpu_hold` drops on entry to DONE or ERR.
- `s_ready` = 1 in HDR_ADDR, HDR_CNT, DATA and CSUM; it is 0 otherwise. Beats offered in IDLE, DONE or ERR are not consumed.
- `start` while `busy`: ignored; no restart.
- Reset mid-load: the loader returns to IDLE immediately, any pending write is dropped, and memory contents already written are left as they are.

## Timing
- Reset values:
  - State is IDLE.
  - `s_ready`, `m_chipselect`, `m_write`, `cpu_hold`, `busy`, `done` and `error` are all 0.
  - `m_address` and `m_writedata` are 0; `m_byteenable` is 4'hF.
- Memory outputs are registered. A DATA beat accepted in cycle t produces `m_chipselect`=`m_write`=1 in cycle t+1 with that beat's address and data, for exactly one cycle.
- The memory has no waitrequest, so one write completes per cycle. Sustained throughput is 1 word/cycle when `s_valid` is held high.
- `busy`, `cpu_hold` and `s_ready` rise in the cycle after `start`.
- `done`/`error` rise in the cycle after the CSUM beat, or the HDR_CNT beat for an illegal count. `cpu_hold` falls in that same cycle.
- The last data write (cycle after beat N) coincides with the CSUM state; a CSUM beat arriving in that same cycle is legal.
- Minimum load time: N+3 accepted beats, plus one cycle.

## Test plan
- Basic load: start, stream addr=0x0010, N=4, data 1,2,3,4, csum=0x0000000A.
  - Required: writes at 0x10..0x13 with data 1..4, one per cycle, each one cycle after its beat.
  - Required: `done`=1, `error`=0, `cpu_hold` falls.
- Wrap-around: addr=0x3FFE, N=4.
  - Required: writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Checksum fail: data 5,6 followed by csum=0x0000000C.
  - Required: `error`=1, `done`=0, `cpu_hold`=0.
- Illegal and zero counts:
  - N=0x4001 → ERR after the HDR_CNT beat, with no writes.
  - N=0 with csum=0 → DONE, with no writes.
- Backpressure and overflow: `s_valid` toggled randomly; data 0xFFFFFFFF, 0x00000002, csum=0x00000001.
  - Required: no dropped or duplicated beats; the sum wraps and `done`=1.
- Reset and start edge cases:
  - `reset_n`=0 for one cycle after 2 of 4 data beats → IDLE, all outputs at reset values, no further writes.
  - `start` asserted while busy → no effect on the load in progress.
